// File: rtl/dmem_pkg.sv
// Shared types and derivation helpers for the banked data memory.
// Request-type encoding (write beats load) and bank/row width functions.
package dmem_pkg;

    typedef enum logic [1:0] {
        REQ_NONE  = 2'd0,
        REQ_LOAD  = 2'd1,
        REQ_WRITE = 2'd2
    } reqType_t;

    function automatic int bankCount(input int bankBits);
        return 1 << bankBits;
    endfunction

    function automatic int bankWidth(input int bankBits);
        return (bankBits > 0) ? bankBits : 1;
    endfunction

    function automatic int rowWidth(input int lmem, input int bankBits);
        return lmem - bankBits;
    endfunction

    function automatic int ptrWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // A store with a simultaneous load strobe is a store.
    function automatic reqType_t decodeReq(input logic ld, input logic wr);
        if (wr) return REQ_WRITE;
        if (ld) return REQ_LOAD;
        return REQ_NONE;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr.
// Ports: req, ptr, advance (enable) in; one-hot gnt and nextPtr out.
module rr_arbiter #(
    parameter int N = 2,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic          advance,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] nextPtr
);

    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        gnt     = '0;
        nextPtr = ptr;
        found   = 1'b0;
        idx     = '0;
        for (int i = 0; i < N; i++) begin
            idx = PW'((int'(ptr) + i) % N);
            if (advance && !found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                nextPtr  = PW'((int'(idx) + 1) % N);
            end
        end
    end

endmodule

// File: rtl/dmem_banked_rr.sv
// Banked multi-core data memory with per-bank round-robin arbitration.
// Ports: clk, rst (async low), per-core dataIN/dataADDR/dataLoad/dataWrite in;
// dataReady (comb grant), dataOUT (registered read), dataValid out.
module dmem_banked_rr
    import dmem_pkg::*;
#(
    parameter int Ncores   = 2,
    parameter int Lmem     = 8,
    parameter int TAM      = 16,
    parameter int BANKBITS = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [Ncores*TAM-1:0] dataIN,
    input  logic [Ncores*TAM-1:0] dataADDR,
    input  logic [Ncores-1:0]     dataLoad,
    input  logic [Ncores-1:0]     dataWrite,
    output logic [Ncores-1:0]     dataReady,
    output logic [Ncores*TAM-1:0] dataOUT,
    output logic [Ncores-1:0]     dataValid
);

    localparam int NB    = bankCount(BANKBITS);
    localparam int BW    = bankWidth(BANKBITS);
    localparam int RW    = rowWidth(Lmem, BANKBITS);
    localparam int PW    = ptrWidth(Ncores);
    localparam int DEPTH = 1 << RW;

    reqType_t          reqType  [Ncores];
    logic [BW-1:0]     coreBank [Ncores];
    logic [RW-1:0]     coreRow  [Ncores];
    logic [Ncores-1:0] bankReq  [NB];
    logic [Ncores-1:0] bankGnt  [NB];
    logic [TAM-1:0]    bankRd   [NB];
    logic [BW-1:0]     selBank  [Ncores];
    logic [TAM-1:0]    hold     [Ncores];
    logic              unusedAddr;

    // Address bits at and above Lmem are ignored.
    assign unusedAddr = ^dataADDR;

    always_comb begin
        for (int k = 0; k < Ncores; k++) begin
            reqType[k]  = decodeReq(dataLoad[k], dataWrite[k]);
            coreRow[k]  = dataADDR[k*TAM+BANKBITS +: RW];
            coreBank[k] = (BANKBITS > 0) ? dataADDR[k*TAM +: BW] : '0;
        end
    end

    always_comb begin
        for (int b = 0; b < NB; b++) begin
            bankReq[b] = '0;
            for (int k = 0; k < Ncores; k++) begin
                bankReq[b][k] = (reqType[k] != REQ_NONE)
                             && (coreBank[k] == BW'(b));
            end
        end
    end

    // Each core maps to one bank, so at most one bank grants it.
    always_comb begin
        dataReady = '0;
        for (int b = 0; b < NB; b++) begin
            for (int k = 0; k < Ncores; k++) begin
                dataReady[k] = dataReady[k] | bankGnt[b][k];
            end
        end
    end

    for (genvar b = 0; b < NB; b++) begin : gBank
        logic [PW-1:0]     ptr;
        logic [PW-1:0]     nextPtr;
        logic [Ncores-1:0] gnt;
        logic              we;
        logic              re;
        logic [RW-1:0]     row;
        logic [TAM-1:0]    wdata;
        logic [TAM-1:0]    rdq;
        logic [TAM-1:0]    mem [DEPTH];

        // advance=rst keeps grants off and pointers frozen in reset.
        rr_arbiter #(.N(Ncores)) uArb (
            .req     (bankReq[b]),
            .ptr     (ptr),
            .advance (rst),
            .gnt     (gnt),
            .nextPtr (nextPtr)
        );

        assign bankGnt[b] = gnt;
        assign bankRd[b]  = rdq;

        always_comb begin
            we    = 1'b0;
            re    = 1'b0;
            row   = '0;
            wdata = '0;
            for (int k = 0; k < Ncores; k++) begin
                if (gnt[k]) begin
                    row   = coreRow[k];
                    wdata = dataIN[k*TAM +: TAM];
                    we    = (reqType[k] == REQ_WRITE);
                    re    = (reqType[k] == REQ_LOAD);
                end
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                ptr <= '0;
            end else begin
                ptr <= nextPtr;
            end
        end

        // Un-reset block so the array stays a plain sync RAM.
        always_ff @(posedge clk) begin
            if (we) begin
                mem[row] <= wdata;
            end
            if (re) begin
                rdq <= mem[row];
            end
        end
    end

    // Bank read register feeds dataOUT during the valid cycle;
    // hold keeps that value until the next valid pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dataValid <= '0;
            for (int k = 0; k < Ncores; k++) begin
                selBank[k] <= '0;
                hold[k]    <= '0;
            end
        end else begin
            for (int k = 0; k < Ncores; k++) begin
                dataValid[k] <= dataReady[k] && (reqType[k] == REQ_LOAD);
                if (dataReady[k] && (reqType[k] == REQ_LOAD)) begin
                    selBank[k] <= coreBank[k];
                end
                if (dataValid[k]) begin
                    hold[k] <= bankRd[selBank[k]];
                end
            end
        end
    end

    always_comb begin
        dataOUT = '0;
        for (int k = 0; k < Ncores; k++) begin
            dataOUT[k*TAM +: TAM] = dataValid[k] ? bankRd[selBank[k]] : hold[k];
        end
    end

endmodule

// File: tb/tb_dmem_banked_rr.sv
// Bench for dmem_banked_rr: vector table, directed reset cases, random run.
// Reference model keeps a flat word array and per-bank rotate pointers.
module tb_dmem_banked_rr;

    localparam int N  = 2;
    localparam int NB = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] dataIN = '0;
    logic [31:0] dataADDR = '0;
    logic [1:0]  dataLoad = '0;
    logic [1:0]  dataWrite = '0;
    logic [1:0]  dataReady;
    logic [31:0] dataOUT;
    logic [1:0]  dataValid;

    int checks = 0;
    int failures = 0;

    logic [15:0] mMem [256];
    int          mPtr [NB];
    logic [1:0]  mValid = '0;
    logic [15:0] mOut [N];

    typedef struct {
        logic [1:0]  ld;
        logic [1:0]  wr;
        logic [15:0] a0;
        logic [15:0] a1;
        logic [15:0] d0;
        logic [15:0] d1;
        logic [1:0]  rdy;
        logic [1:0]  vld;
        logic [15:0] o0;
        logic [15:0] o1;
    } vec_t;

    vec_t vec [16];

    dmem_banked_rr #(
        .Ncores(2), .Lmem(8), .TAM(16), .BANKBITS(1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .dataIN    (dataIN),
        .dataADDR  (dataADDR),
        .dataLoad  (dataLoad),
        .dataWrite (dataWrite),
        .dataReady (dataReady),
        .dataOUT   (dataOUT),
        .dataValid (dataValid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        mValid = '0;
        for (int k = 0; k < N; k++) mOut[k] = '0;
        for (int b = 0; b < NB; b++) mPtr[b] = 0;
    endtask

    // Drive one cycle, check against the model, advance the model.
    task automatic cycle(input logic [1:0] ld, input logic [1:0] wr,
                         input logic [15:0] a0, input logic [15:0] a1,
                         input logic [15:0] d0, input logic [15:0] d1,
                         input string tag, output logic [1:0] oRdy,
                         output logic [1:0] oVld, output logic [31:0] oOut);
        logic [15:0] ad [N];
        logic [15:0] dd [N];
        logic [1:0]  req;
        logic [1:0]  exp;
        ad[0] = a0; ad[1] = a1; dd[0] = d0; dd[1] = d1;
        dataLoad = ld; dataWrite = wr;
        dataADDR = {a1, a0}; dataIN = {d1, d0};
        req = ld | wr;
        exp = '0;
        if (rst) begin
            for (int b = 0; b < NB; b++) begin
                for (int i = 0; i < N; i++) begin
                    int c;
                    c = (mPtr[b] + i) % N;
                    if (req[c] && (int'(ad[c][7:0]) % NB) == b) begin
                        exp[c] = 1'b1;
                        break;
                    end
                end
            end
        end
        @(negedge clk);
        oRdy = dataReady; oVld = dataValid; oOut = dataOUT;
        chk({tag, " ready"}, 32'(dataReady), 32'(exp));
        chk({tag, " valid"}, 32'(dataValid), 32'(mValid));
        chk({tag, " out"}, dataOUT, {mOut[1], mOut[0]});
        @(posedge clk);
        if (rst) begin
            mValid = '0;
            for (int k = 0; k < N; k++) begin
                if (exp[k]) begin
                    if (wr[k]) begin
                        mMem[ad[k][7:0]] = dd[k];
                    end else begin
                        mValid[k] = 1'b1;
                        mOut[k] = mMem[ad[k][7:0]];
                    end
                    mPtr[int'(ad[k][7:0]) % NB] = (k + 1) % N;
                end
            end
        end
        #1;
    endtask

    initial begin
        logic [1:0]  r;
        logic [1:0]  v;
        logic [31:0] o;
        logic [1:0]  pl;
        logic [1:0]  pw;
        logic [1:0]  pend;
        logic [15:0] pa [N];
        logic [15:0] pd [N];

        vec[0]  = '{2'b00, 2'b11, 16'h10, 16'h11, 16'h1234, 16'hBEEF, 2'b11, 2'b00, 16'h0, 16'h0};
        vec[1]  = '{2'b11, 2'b00, 16'h10, 16'h11, 16'h0, 16'h0, 2'b11, 2'b00, 16'h0, 16'h0};
        vec[2]  = '{2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0, 2'b00, 2'b11, 16'h1234, 16'hBEEF};
        vec[3]  = '{2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0, 2'b00, 2'b00, 16'h1234, 16'hBEEF};
        vec[4]  = '{2'b00, 2'b10, 16'h0, 16'h12, 16'h0, 16'hC0DE, 2'b10, 2'b00, 16'h1234, 16'hBEEF};
        vec[5]  = '{2'b11, 2'b00, 16'h20, 16'h20, 16'h0, 16'h0, 2'b01, 2'b00, 16'h1234, 16'hBEEF};
        vec[6]  = '{2'b10, 2'b00, 16'h0, 16'h20, 16'h0, 16'h0, 2'b10, 2'b01, 16'h20DF, 16'hBEEF};
        vec[7]  = '{2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0, 2'b00, 2'b10, 16'h20DF, 16'h20DF};
        vec[8]  = '{2'b01, 2'b01, 16'h05, 16'h0, 16'h00AA, 16'h0, 2'b01, 2'b00, 16'h20DF, 16'h20DF};
        vec[9]  = '{2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0, 2'b00, 2'b00, 16'h20DF, 16'h20DF};
        vec[10] = '{2'b01, 2'b00, 16'h05, 16'h0, 16'h0, 16'h0, 2'b01, 2'b00, 16'h20DF, 16'h20DF};
        vec[11] = '{2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0, 2'b00, 2'b01, 16'h00AA, 16'h20DF};
        vec[12] = '{2'b00, 2'b10, 16'h0, 16'h0103, 16'h0, 16'h7777, 2'b10, 2'b00, 16'h00AA, 16'h20DF};
        vec[13] = '{2'b10, 2'b00, 16'h0, 16'h0003, 16'h0, 16'h0, 2'b10, 2'b00, 16'h00AA, 16'h20DF};
        vec[14] = '{2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0, 2'b00, 2'b10, 16'h00AA, 16'h7777};
        vec[15] = '{2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0, 2'b00, 2'b00, 16'h00AA, 16'h7777};

        modelReset();
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Reset held with random traffic.
        for (int i = 0; i < 3; i++) begin
            cycle(2'($urandom), 2'($urandom), 16'($urandom), 16'($urandom),
                  16'($urandom), 16'($urandom), "reset", r, v, o);
            chk("reset ready zero", 32'(r), 32'h0);
        end
        rst = 1'b1;
        cycle(2'b00, 2'b11, 16'h00, 16'h00, 16'h1111, 16'h2222,
              "first", r, v, o);
        chk("first grant core0", 32'(r), 32'h1);

        // Fill: core0 even words, core1 odd words, no conflicts.
        for (int i = 0; i < 128; i++) begin
            logic [7:0] e;
            logic [7:0] f;
            e = 8'(2 * i);
            f = 8'(2 * i + 1);
            cycle(2'b00, 2'b11, {8'h00, e}, {8'h00, f},
                  {e, ~e}, {f, ~f}, "fill", r, v, o);
        end

        for (int i = 0; i < 16; i++) begin
            cycle(vec[i].ld, vec[i].wr, vec[i].a0, vec[i].a1,
                  vec[i].d0, vec[i].d1, $sformatf("vec%0d", i), r, v, o);
            chk($sformatf("vec%0d tbl ready", i), 32'(r), 32'(vec[i].rdy));
            chk($sformatf("vec%0d tbl valid", i), 32'(v), 32'(vec[i].vld));
            chk($sformatf("vec%0d tbl out", i), o, {vec[i].o1, vec[i].o0});
        end

        // Reset between the grant edge and the data cycle.
        cycle(2'b01, 2'b00, 16'h10, 16'h0, 16'h0, 16'h0, "rmr ld", r, v, o);
        chk("rmr grant", 32'(r), 32'h1);
        rst = 1'b0;
        #1;
        chk("rmr valid dropped", 32'(dataValid), 32'h0);
        chk("rmr out cleared", dataOUT, 32'h0);
        modelReset();
        for (int i = 0; i < 2; i++) begin
            cycle(2'b11, 2'b00, 16'h10, 16'h10, 16'h0, 16'h0, "rmr hold",
                  r, v, o);
        end
        rst = 1'b1;
        cycle(2'b11, 2'b00, 16'h10, 16'h10, 16'h0, 16'h0, "rmr re1", r, v, o);
        chk("rmr ptr restart", 32'(r), 32'h1);
        cycle(2'b10, 2'b00, 16'h0, 16'h10, 16'h0, 16'h0, "rmr re2", r, v, o);
        chk("rmr re2 grant", 32'(r), 32'h2);
        chk("rmr re2 data", o, {16'h0, 16'h1234});
        cycle(2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0, "rmr re3", r, v, o);
        chk("rmr re3 data", o, {16'h1234, 16'h1234});

        // Random traffic; ungranted requests are held or sometimes dropped.
        pend = '0; pl = '0; pw = '0;
        pa[0] = '0; pa[1] = '0; pd[0] = '0; pd[1] = '0;
        for (int t = 0; t < 600; t++) begin
            for (int k = 0; k < N; k++) begin
                if (!pend[k] || $urandom_range(7) == 0) begin
                    case ($urandom_range(3))
                        0: begin pl[k] = 1'b0; pw[k] = 1'b0; end
                        1: begin pl[k] = 1'b1; pw[k] = 1'b0; end
                        2: begin pl[k] = 1'b0; pw[k] = 1'b1; end
                        default: begin pl[k] = 1'b1; pw[k] = 1'b1; end
                    endcase
                    pa[k] = 16'($urandom);
                    pd[k] = 16'($urandom);
                end
            end
            cycle(pl, pw, pa[0], pa[1], pd[0], pd[1], "rnd", r, v, o);
            pend = (pl | pw) & ~r;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_banked_rr.md
Name: dmem_banked_rr

Overview:
- Parametrised multi-core data memory: Ncores independent load/store ports share a banked on-chip RAM of 2^Lmem words of TAM bits.
- Per-bank round-robin arbitration with a req/ready handshake and a registered read path (dataValid per core).
- Successor to the fixed 2-port data memory. Sits between the core load/store stages and the data address space.

Parameters:
- Ncores, 2, number of core ports (>=1).
- Lmem, 8, word-address width; depth = 2^Lmem words.
- TAM, 16, data and address width in bits.
- BANKBITS, 1, log2 of bank count; banks = 2^BANKBITS, 0 <= BANKBITS < Lmem.

Ports:
- clk  in  1  system clock. Single clock domain; all state changes on its rising edge.
- rst  in  1  reset, asynchronous, active-low.
- dataIN  in  Ncores*TAM  write data; core k occupies slice k.
- dataADDR  in  Ncores*TAM  word address per core; only bits [Lmem-1:0] are used.
- dataLoad  in  Ncores  load request per core.
- dataWrite  in  Ncores  store request per core.
- dataReady  out  Ncores  grant. Combinational, same cycle as the request.
- dataOUT  out  Ncores*TAM  read data per core, registered.
- dataValid  out  Ncores  one-cycle pulse marking new dataOUT for that core.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset (rst=0), asynchronous:
  - dataOUT = 0, dataValid = 0.
  - All round-robin pointers = 0.
  - RAM contents are not reset (RAM must stay inferable).
  - dataReady = 0 while rst = 0.
- Request decoding:
  - Core k requests when dataLoad[k] | dataWrite[k].
  - If both are set, the access is a write. The load is ignored and no dataValid follows.
- Bank mapping:
  - bank = addr[BANKBITS-1:0].
  - Row = addr[Lmem-1:BANKBITS].
  - Address bits >= Lmem are ignored, so addresses wrap modulo 2^Lmem.
- Arbitration, per bank, every cycle:
  - Search requesting cores for that bank starting at ptr[bank], ascending, modulo Ncores. The first hit is granted.
  - At most one grant per bank per cycle. Different banks grant in parallel.
  - dataReady[k] = 1 only for the granted cores.
  - On grant to core g: ptr[bank] <= (g+1) mod Ncores at the clock edge.
  - A bank with no request keeps its pointer.
- Handshake:
  - A request is consumed on the edge where dataReady = 1.
  - A core without ready must hold its address, data and strobes unchanged until granted.
  - Dropping a request before grant is allowed and has no side effect.
- Write: a granted write updates the RAM at the edge. A read granted in any later cycle returns the new value.
- Read latency:
  - A granted load at edge N gives dataOUT[k] = RAM[addr] and dataValid[k] = 1 during cycle N+1.
  - dataValid returns to 0 afterwards unless another load is granted.
  - dataOUT holds its last value between valid pulses.
- Same-cycle hazards: two accesses to one address always share a bank, so only one is granted per cycle. No read/write collision exists.
- Fairness: with Ncores persistent requesters on one bank, each core is granted exactly once per Ncores cycles.
- Reset mid-operation: in-flight read is dropped (no dataValid), pointers return to 0, and pending requests are re-arbitrated after rst deasserts.

Decomposition:
- Package dmem_pkg holds:
  - bank-index and row-width derivation functions from Lmem and BANKBITS.
  - the request-type encoding REQ_NONE, REQ_LOAD, REQ_WRITE (write priority).
- Sub-module rr_arbiter #(N):
  - inputs: req[N], ptr, advance.
  - outputs: one-hot gnt[N] and the next pointer.
  - One instance per bank, via a generate loop.

Test Plan:
- Reset: hold rst=0 for 3 cycles with random requests -> dataReady=0, dataValid=0, dataOUT=0. After release, the first grant on a bank goes to core 0.
- Write then read, no conflict: core0 writes 0x1234 to addr 0x10 and core1 writes 0xBEEF to addr 0x11 in the same cycle -> both dataReady=1. Next cycle both load the same addresses -> after 1 cycle dataOUT0=0x1234, dataOUT1=0xBEEF, dataValid=2'b11 for exactly one cycle.
- Bank conflict round-robin: both cores load addr 0x20 and hold the request -> cycle 1 grants core0, cycle 2 grants core1. Each core sees dataValid exactly once. The pointer for bank 0 alternates.
- Load+write on the same core: core0 sets dataLoad=dataWrite=1 with addr 0x05 and data 0x00AA -> treated as write, no dataValid. A later load of 0x05 returns 0x00AA.
- Address wrap: core1 writes 0x7777 at dataADDR=0x0103 (Lmem=8), then loads 0x0003 -> dataOUT1=0x7777.
- Reset mid-read: assert rst between the grant edge and the next edge -> dataValid stays 0 and dataOUT=0. A reissued load returns the RAM value written before reset.
